// File: rtl/im2col_scheduler_pkg.sv
// Shared im2col scheduler types: RAM geometry, job descriptor, generator command, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package im2ColPckg;

    // Feature-map RAM geometry and kernel size limits
    parameter int cNumOfRam     = 16;
    parameter int cRamDepth     = 64;
    parameter int cMaxKerWidth  = 4;
    parameter int cMaxKerHeight = 4;

    // Field widths: enough bits to hold (limit - 1)
    localparam int cXW = $clog2(cNumOfRam - 1);
    localparam int cYW = $clog2(cRamDepth - 1);
    localparam int cKW = (cMaxKerWidth  > 2) ? $clog2(cMaxKerWidth - 1)  : 1;
    localparam int cHW = (cMaxKerHeight > 2) ? $clog2(cMaxKerHeight - 1) : 1;

    typedef enum logic [1:0] {
        sIdle   = 2'd0,
        sIssue  = 2'd1,
        sFinish = 2'd2
    } tIm2ColSchedState;

    // Latched job descriptor; all sizes are stored minus one
    typedef struct packed {
        logic [cKW-1:0] kerW;
        logic [cHW-1:0] kerH;
        logic [cXW-1:0] outW;
        logic [cYW-1:0] outH;
        logic [cYW-1:0] baseY;
    } tIm2ColJob;

    // One row fetch request for the im2col address generator; dv is the valid
    typedef struct packed {
        logic           dv;
        logic [cKW-1:0] kerWidth;
        logic [cXW-1:0] startAddrX;
        logic [cYW-1:0] startAddrY;
    } tIm2ColIn;

endpackage

// File: rtl/im2col_scheduler_loop_cnt.sv
// Three-level nested counter (ky innermost, then ox, then oy) with per-level wrap flags.
// Latency: counters update on the clock edge after step; wrap flags are combinational from step.
// Backpressure: only advances when step is high, holds otherwise.
module im2col_loop_cnt #(
    parameter int HW = 2,
    parameter int XW = 4,
    parameter int YW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          step,
    input  logic [HW-1:0] kerH,
    input  logic [XW-1:0] outW,
    input  logic [YW-1:0] outH,
    output logic [HW-1:0] ky,
    output logic [XW-1:0] ox,
    output logic [YW-1:0] oy,
    output logic          kyWrap,
    output logic          oxWrap,
    output logic          oyWrap
);

    logic kyLast;
    logic oxLast;
    logic oyLast;

    // Terminal-count detection per level and the wrap chain; oyWrap marks the final step
    always_comb begin
        kyLast = (ky == kerH);
        oxLast = (ox == outW);
        oyLast = (oy == outH);
        kyWrap = step && kyLast;
        oxWrap = kyWrap && oxLast;
        oyWrap = oxWrap && oyLast;
    end

    // Nested increment; every level returns to zero after its last value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ky <= '0;
            ox <= '0;
            oy <= '0;
        end else if (clr) begin
            ky <= '0;
            ox <= '0;
            oy <= '0;
        end else if (step) begin
            if (kyLast) begin
                ky <= '0;
                if (oxLast) begin
                    ox <= '0;
                    oy <= oyLast ? '0 : oy + 1'b1;
                end else begin
                    ox <= ox + 1'b1;
                end
            end else begin
                ky <= ky + 1'b1;
            end
        end
    end

endmodule

// File: rtl/im2col_scheduler.sv
// Expands one im2col job descriptor into a stream of per-row generator commands.
// Latency: first command one cycle after job accept, then one per cycle; jobDone one cycle after last accept.
// Backpressure: cmd held stable while cmdReady is low; jobReady only in idle, jobs are never queued.
module im2col_scheduler #(
    parameter  int cMaxKerHeight = im2ColPckg::cMaxKerHeight,
    localparam int XW = im2ColPckg::cXW,
    localparam int YW = im2ColPckg::cYW,
    localparam int KW = im2ColPckg::cKW,
    localparam int HW = (cMaxKerHeight > 2) ? $clog2(cMaxKerHeight - 1) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 jobValid,
    output logic                 jobReady,
    input  logic [KW-1:0]        jobKerW,
    input  logic [HW-1:0]        jobKerH,
    input  logic [XW-1:0]        jobOutW,
    input  logic [YW-1:0]        jobOutH,
    input  logic [YW-1:0]        jobBaseY,
    output im2ColPckg::tIm2ColIn cmd,
    input  logic                 cmdReady,
    output logic                 colDone,
    output logic                 jobDone,
    output logic                 jobErr,
    output logic                 busy
);

    import im2ColPckg::*;

    tIm2ColSchedState state;
    tIm2ColSchedState stateNxt;
    tIm2ColJob        job;

    logic          accept;
    logic          badJob;
    logic          acceptErr;
    logic          acceptOk;
    logic          step;
    logic [XW:0]   xSum;
    logic [YW+1:0] ySum;

    logic [HW-1:0] ky;
    logic [XW-1:0] ox;
    logic [YW-1:0] oy;
    logic          kyWrap;
    logic          oxWrap;
    logic          oyWrap;

    // Bounds check on the incoming descriptor, done at widened width so sums never wrap
    always_comb begin
        xSum   = {1'b0, jobOutW} + (XW+1)'(jobKerW);
        ySum   = (YW+2)'(jobBaseY) + (YW+2)'(jobOutH) + (YW+2)'(jobKerH);
        badJob = (xSum > (XW+1)'(cNumOfRam - 1)) || (ySum > (YW+2)'(cRamDepth - 1));
    end

    // Next state, handshakes and the command word; cmd is all zero whenever it is not valid
    always_comb begin
        stateNxt  = state;
        jobReady  = 1'b0;
        busy      = 1'b1;
        jobDone   = 1'b0;
        accept    = 1'b0;
        acceptErr = 1'b0;
        acceptOk  = 1'b0;
        step      = 1'b0;
        cmd       = '0;
        case (state)
            sIdle: begin
                jobReady  = 1'b1;
                busy      = 1'b0;
                accept    = jobValid;
                acceptErr = jobValid && badJob;
                acceptOk  = jobValid && !badJob;
                if (acceptOk) begin
                    stateNxt = sIssue;
                end
            end
            sIssue: begin
                cmd.dv         = 1'b1;
                cmd.kerWidth   = job.kerW;
                cmd.startAddrX = ox;
                cmd.startAddrY = job.baseY + oy + YW'(ky);
                step           = cmdReady;
                if (oyWrap) begin
                    stateNxt = sFinish;
                end
            end
            sFinish: begin
                jobDone  = 1'b1;
                stateNxt = sIdle;
            end
            default: begin
                stateNxt = sIdle;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= sIdle;
        end else begin
            state <= stateNxt;
        end
    end

    // Latch the descriptor on any accept; rejected jobs never leave idle so the copy is harmless
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            job <= '0;
        end else if (accept) begin
            job.kerW  <= jobKerW;
            job.kerH  <= jobKerH;
            job.outW  <= jobOutW;
            job.outH  <= jobOutH;
            job.baseY <= jobBaseY;
        end
    end

    // Single-cycle status pulses: window finished, job rejected
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            colDone <= 1'b0;
            jobErr  <= 1'b0;
        end else begin
            colDone <= kyWrap;
            jobErr  <= acceptErr;
        end
    end

    im2col_loop_cnt #(
        .HW (HW),
        .XW (XW),
        .YW (YW)
    ) u_loop_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (acceptOk),
        .step   (step),
        .kerH   (job.kerH),
        .outW   (job.outW),
        .outH   (job.outH),
        .ky     (ky),
        .ox     (ox),
        .oy     (oy),
        .kyWrap (kyWrap),
        .oxWrap (oxWrap),
        .oyWrap (oyWrap)
    );

endmodule

// File: tb/tb_im2col_scheduler.sv
// Self-checking bench for im2col_scheduler: job vector table plus command scoreboard.
// Latency: n/a.
// Backpressure: stalls cmdReady per vector to exercise command hold.
module tb_im2col_scheduler;
    import im2ColPckg::*;

    localparam int XW = cXW;
    localparam int YW = cYW;
    localparam int KW = cKW;
    localparam int HW = cHW;

    logic          clk = 1'b0;
    logic          rst;
    logic          jobValid;
    logic          jobReady;
    logic [KW-1:0] jobKerW;
    logic [HW-1:0] jobKerH;
    logic [XW-1:0] jobOutW;
    logic [YW-1:0] jobOutH;
    logic [YW-1:0] jobBaseY;
    tIm2ColIn      cmd;
    logic          cmdReady;
    logic          colDone;
    logic          jobDone;
    logic          jobErr;
    logic          busy;

    im2col_scheduler dut (
        .clk      (clk),
        .rst      (rst),
        .jobValid (jobValid),
        .jobReady (jobReady),
        .jobKerW  (jobKerW),
        .jobKerH  (jobKerH),
        .jobOutW  (jobOutW),
        .jobOutH  (jobOutH),
        .jobBaseY (jobBaseY),
        .cmd      (cmd),
        .cmdReady (cmdReady),
        .colDone  (colDone),
        .jobDone  (jobDone),
        .jobErr   (jobErr),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kerW;
        int kerH;
        int outW;
        int outH;
        int baseY;
        bit expErr;
        int stallIdx;
        int stallLen;
        bit poke;
    } vec_t;

    typedef struct {
        int x;
        int y;
        bit last;
    } exp_t;

    vec_t vecs[7];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_job(input vec_t v);
        jobKerW  = KW'(v.kerW);
        jobKerH  = HW'(v.kerH);
        jobOutW  = XW'(v.outW);
        jobOutH  = YW'(v.outH);
        jobBaseY = YW'(v.baseY);
        jobValid = 1'b1;
    endtask

    task automatic run_job(input vec_t v, input string tag);
        int n = 0;
        int stall = 0;
        int cyc = 0;
        bit prevLast = 1'b0;
        bit rdy;
        if (!v.expErr) begin
            for (int oy = 0; oy <= v.outH; oy++)
                for (int ox = 0; ox <= v.outW; ox++)
                    for (int ky = 0; ky <= v.kerH; ky++)
                        sb.push_back('{ox, v.baseY + oy + ky, (ky == v.kerH)});
        end
        @(negedge clk);
        chk({tag, " jobReady idle"}, 32'(jobReady), 32'd1);
        drive_job(v);
        @(negedge clk);
        jobValid = 1'b0;
        if (v.expErr) begin
            chk({tag, " jobErr pulse"}, 32'(jobErr), 32'd1);
            chk({tag, " busy on err"}, 32'(busy), 32'd0);
            chk({tag, " dv on err"}, 32'(cmd.dv), 32'd0);
            @(negedge clk);
            chk({tag, " jobErr clears"}, 32'(jobErr), 32'd0);
            chk({tag, " dv after err"}, 32'(cmd.dv), 32'd0);
            chk({tag, " ready after err"}, 32'(jobReady), 32'd1);
            return;
        end
        while (sb.size() > 0 && cyc < 2000) begin
            cyc++;
            chk({tag, " dv"}, 32'(cmd.dv), 32'd1);
            chk({tag, " jobReady busy"}, 32'(jobReady), 32'd0);
            chk({tag, " colDone"}, 32'(colDone), 32'(prevLast));
            chk({tag, " jobDone early"}, 32'(jobDone), 32'd0);
            chk({tag, " x"}, 32'(cmd.startAddrX), 32'(sb[0].x));
            chk({tag, " y"}, 32'(cmd.startAddrY), 32'(sb[0].y));
            chk({tag, " kerWidth"}, 32'(cmd.kerWidth), 32'(v.kerW));
            rdy = !(n == v.stallIdx && stall < v.stallLen);
            if (!rdy) stall++;
            cmdReady = rdy;
            // Junk job offered while issuing; it must be ignored
            if (v.poke && !rdy) begin
                jobKerW  = '1;
                jobOutW  = 3;
                jobBaseY = 1;
                jobValid = 1'b1;
            end else begin
                jobValid = 1'b0;
            end
            prevLast = 1'b0;
            if (rdy) begin
                prevLast = sb[0].last;
                void'(sb.pop_front());
                n++;
            end
            @(negedge clk);
        end
        jobValid = 1'b0;
        cmdReady = 1'b1;
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: %0d cmds outstanding, required 0", tag, sb.size());
            sb.delete();
        end
        chk({tag, " finish dv"}, 32'(cmd.dv), 32'd0);
        chk({tag, " jobDone"}, 32'(jobDone), 32'd1);
        chk({tag, " last colDone"}, 32'(colDone), 32'(prevLast));
        chk({tag, " busy finish"}, 32'(busy), 32'd1);
        @(negedge clk);
        chk({tag, " jobDone clears"}, 32'(jobDone), 32'd0);
        chk({tag, " idle busy"}, 32'(busy), 32'd0);
        chk({tag, " idle ready"}, 32'(jobReady), 32'd1);
        chk({tag, " idle colDone"}, 32'(colDone), 32'd0);
    endtask

    initial begin
        //           kerW kerH outW outH baseY err  stIdx stLen poke
        vecs[0] = '{2,   2,   1,   0,   5,    1'b0, -1,   0,    1'b0};
        vecs[1] = '{2,   2,   1,   0,   5,    1'b0, 1,    3,    1'b0};
        vecs[2] = '{3,   0,   cNumOfRam-2, 0, 0, 1'b1, -1, 0,    1'b0};
        vecs[3] = '{1,   2,   0,   2,   60,   1'b1, -1,   0,    1'b0};
        vecs[4] = '{3,   2,   12,  1,   60,   1'b0, 7,    2,    1'b0};
        vecs[5] = '{0,   0,   0,   0,   9,    1'b0, 0,    2,    1'b1};
        vecs[6] = '{1,   1,   2,   1,   0,    1'b0, 4,    2,    1'b0};

        rst      = 1'b1;
        jobValid = 1'b0;
        cmdReady = 1'b1;
        jobKerW  = '0;
        jobKerH  = '0;
        jobOutW  = '0;
        jobOutH  = '0;
        jobBaseY = '0;
        #1;
        chk("reset dv", 32'(cmd.dv), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset jobDone", 32'(jobDone), 32'd0);
        chk("reset jobErr", 32'(jobErr), 32'd0);
        chk("reset colDone", 32'(colDone), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post-reset ready", 32'(jobReady), 32'd1);

        for (int i = 0; i < 7; i++) begin
            run_job(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset mid-job after the fourth accepted command
        @(negedge clk);
        cmdReady = 1'b1;
        drive_job(vecs[0]);
        @(negedge clk);
        jobValid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("midjob dv", 32'(cmd.dv), 32'd1);
        chk("midjob x", 32'(cmd.startAddrX), 32'd1);
        chk("midjob y", 32'(cmd.startAddrY), 32'd6);
        rst = 1'b1;
        #1;
        chk("async rst dv", 32'(cmd.dv), 32'd0);
        chk("async rst x", 32'(cmd.startAddrX), 32'd0);
        chk("async rst y", 32'(cmd.startAddrY), 32'd0);
        chk("async rst kerWidth", 32'(cmd.kerWidth), 32'd0);
        chk("async rst busy", 32'(busy), 32'd0);
        chk("async rst colDone", 32'(colDone), 32'd0);
        chk("async rst jobDone", 32'(jobDone), 32'd0);
        chk("async rst jobErr", 32'(jobErr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("after rst ready", 32'(jobReady), 32'd1);
        chk("after rst no resume", 32'(cmd.dv), 32'd0);
        run_job(vecs[0], "restart");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/im2col_scheduler.md
IM2COL_SCHEDULER -- requirements
Module: im2col_scheduler

Interface
REQ-001 SHALL have parameter: cMaxKerHeight, 4, maximum kernel height in rows; kernel width limit is the shared package constant cMaxKerWidth (4).
REQ-002 SHALL define widths XW = log2(cNumOfRam-1), YW = log2(cRamDepth-1), KW = log2(cMaxKerWidth-1), HW = log2(cMaxKerHeight-1).
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  clock, all state on rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 jobValid  in  1  job descriptor valid.
REQ-007 jobReady  out  1  scheduler can accept a job.
REQ-008 jobKerW  in  KW  kernel width minus 1.
REQ-009 jobKerH  in  HW  kernel height minus 1.
REQ-010 jobOutW  in  XW  output columns minus 1.
REQ-011 jobOutH  in  YW  output rows minus 1.
REQ-012 jobBaseY  in  YW  first RAM row of the feature map.
REQ-013 cmd  out  tIm2ColIn  command to the im2col address generator; cmd.dv is the valid.
REQ-014 cmdReady  in  1  generator accepts cmd this cycle.
REQ-015 colDone  out  1  one-cycle pulse: last row of one window accepted.
REQ-016 jobDone  out  1  one-cycle pulse: job complete.
REQ-017 jobErr  out  1  one-cycle pulse: job rejected.
REQ-018 busy  out  1  high in any state except sIdle.

Function
REQ-019 SHALL implement states sIdle, sIssue, sFinish; jobReady = 1 only in sIdle.
REQ-020 SHALL accept a job when jobValid && jobReady, latching all descriptor fields.
REQ-021 On acceptance SHALL reject if jobOutW + jobKerW > cNumOfRam-1 or jobBaseY + jobOutH + jobKerH > cRamDepth-1 (compared at width+1, no wrap): jobErr = 1 next cycle, state stays sIdle, no cmd issued.
REQ-022 Otherwise SHALL enter sIssue next cycle with cmd.dv = 1 and the first command.
REQ-023 Loop order SHALL be ky innermost (0..kerH), then ox (0..outW), then oy (0..outH); total commands = (outW+1)(outH+1)(kerH+1).
REQ-024 Each command SHALL carry kerWidth = jobKerW, startAddrX = ox, startAddrY = jobBaseY + oy + ky.
REQ-025 While cmd.dv && !cmdReady, cmd SHALL hold every field stable.
REQ-026 On cmd.dv && cmdReady the counters SHALL advance and the next command SHALL be presented the following cycle, giving one command per cycle when cmdReady stays high.
REQ-027 colDone SHALL pulse in the cycle after a command with ky = kerH is accepted.
REQ-028 After the last command is accepted SHALL enter sFinish for exactly one cycle with cmd.dv = 0 and jobDone = 1, then sIdle.
REQ-029 jobValid outside sIdle SHALL be ignored; the job is not queued.
REQ-030 A 1x1 job (all fields 0) SHALL issue exactly one command.

Reset
REQ-031 rst SHALL force sIdle, all counters to 0, cmd = all zero, and colDone, jobDone, jobErr and busy to 0, immediately and asynchronously, including mid-job.
REQ-032 After rst deasserts, jobReady SHALL be 1 and no partial job SHALL resume.

Structure
REQ-033 The state enum tIm2ColSchedState and a packed job descriptor struct tIm2ColJob SHALL live in im2ColPckg; cMaxKerHeight SHALL be a parameter there.
REQ-034 The ky/ox/oy nested counter SHALL be one sub-module, im2col_loop_cnt, with step input and per-level wrap outputs.

Verification
REQ-035 kerW=2, kerH=2, outW=1, outH=0, baseY=5, cmdReady=1 -> 6 back-to-back cmds (x,y): (0,5)(0,6)(0,7)(1,5)(1,6)(1,7); colDone after the 3rd and 6th; jobDone one cycle after the last.
REQ-036 Same job, cmdReady low for 3 cycles on the 2nd cmd -> cmd held at (0,6) for 3 cycles, sequence otherwise unchanged.
REQ-037 jobOutW = cNumOfRam-2, jobKerW = 3 -> jobErr pulse, busy stays 0, no cmd.dv.
REQ-038 rst asserted after the 4th cmd accept -> all outputs 0 the same cycle; a new job afterwards starts at ky=ox=oy=0.
REQ-039 All fields 0 -> one cmd (0,baseY), colDone, then jobDone; jobValid during sIssue is ignored.
